key_msg_tx: RTL and testbench



---
 rtl/key_msg_tx_pkg.sv | 30 +++
 rtl/key_msg_tx_if.sv | 17 +
 rtl/key_msg_tx_hex_to_ascii.sv | 27 ++
 rtl/key_msg_tx.sv | 108 ++++++++++
 tb/tb_key_msg_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_msg_tx_pkg.sv
// ============================================================================
// key_msg_tx_pkg
// Shared state encodings, ASCII constants and message length for key_msg_tx.
// Optional macro KEY_MSG_CRLF_EN extends the message with CR/LF.
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_msg_tx_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_UC_OFS = 8'h37;
    localparam logic [7:0] ASCII_LC_OFS = 8'h57;

`ifdef KEY_MSG_CRLF_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

endpackage

`default_nettype wire

// File: rtl/key_msg_tx_if.sv
// ============================================================================
// key_msg_tx_if
// UART TX FIFO write port: write strobe, data byte and full flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface key_msg_tx_if;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;

    modport master (input tx_full, output wr_uart, output w_data);
    modport slave  (output tx_full, input wr_uart, input w_data);
endinterface

`default_nettype wire

// File: rtl/key_msg_tx_hex_to_ascii.sv
// ============================================================================
// key_msg_tx_hex_to_ascii
// Combinational nibble to ASCII hex digit, upper or lower case letters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_msg_tx_hex_to_ascii
    import key_msg_tx_pkg::*;
#(
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASCII_0 + {4'b0000, nib_i};
        end else begin
            ascii_o = (HEX_UPPER ? ASCII_UC_OFS : ASCII_LC_OFS) + {4'b0000, nib_i};
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_msg_tx.sv
// ============================================================================
// key_msg_tx
// Counts debounced presses and writes "P=<hh>" into the UART TX FIFO.
// Optional macro KEY_MSG_CRLF_EN appends CR LF to every message.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_msg_tx
    import key_msg_tx_pkg::*;
#(
    parameter logic [7:0] PREFIX0   = 8'h50,
    parameter logic [7:0] PREFIX1   = 8'h3D,
    parameter bit         HEX_UPPER = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        btn_tick,
    key_msg_tx_if.master     fifo,
    output logic             busy,
    output logic [7:0]       press_cnt,
    output logic             drop_tick
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hex_hi_w, hex_lo_w, byte_w;
    logic       wr_w;
    logic [7:0] data_w;

    key_msg_tx_hex_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_hex_hi (
        .nib_i   (cnt_q[7:4]),
        .ascii_o (hex_hi_w)
    );

    key_msg_tx_hex_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_hex_lo (
        .nib_i   (cnt_q[3:0]),
        .ascii_o (hex_lo_w)
    );

    always_comb begin
        case (idx_q)
            3'd0:    byte_w = PREFIX0;
            3'd1:    byte_w = PREFIX1;
            3'd2:    byte_w = hex_hi_w;
            3'd3:    byte_w = hex_lo_w;
`ifdef KEY_MSG_CRLF_EN
            3'd4:    byte_w = ASCII_CR;
            3'd5:    byte_w = ASCII_LF;
`endif
            default: byte_w = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write strobe and data are combinational so the FIFO samples them on the same edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wr_w      = 1'b0;
        data_w    = 8'h00;
        busy      = 1'b0;
        drop_tick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_tick) begin
                    cnt_d   = cnt_q + 8'd1;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                drop_tick = btn_tick;
                data_w    = byte_w;
                if (!fifo.tx_full) begin
                    wr_w = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo.wr_uart = wr_w;
    assign fifo.w_data  = data_w;
    assign press_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_key_msg_tx.sv
// ============================================================================
// tb_key_msg_tx
// Directed self-checking bench for key_msg_tx (default build, no CR/LF).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_msg_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_tick;
    logic       busy, drop_tick, lc_busy, lc_drop;
    logic [7:0] press_cnt, lc_cnt;

    int total = 0;
    int bad   = 0;

    logic       s_wr, s_busy, s_drop;
    logic [7:0] s_data, s_lc_data, s_cnt;

    key_msg_tx_if kif ();
    key_msg_tx_if lif ();

    key_msg_tx u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_tick  (btn_tick),
        .fifo      (kif.master),
        .busy      (busy),
        .press_cnt (press_cnt),
        .drop_tick (drop_tick)
    );

    key_msg_tx #(.HEX_UPPER(1'b0)) u_lc (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_tick  (btn_tick),
        .fifo      (lif.master),
        .busy      (lc_busy),
        .press_cnt (lc_cnt),
        .drop_tick (lc_drop)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs just after a rising edge, sample at the falling edge.
    task automatic cyc(input logic tick, input logic full);
        btn_tick    = tick;
        kif.tx_full = full;
        lif.tx_full = full;
        @(negedge clk);
        s_wr      = kif.wr_uart;
        s_data    = kif.w_data;
        s_lc_data = lif.w_data;
        s_busy    = busy;
        s_drop    = drop_tick;
        s_cnt     = press_cnt;
        @(posedge clk);
        #1;
        btn_tick    = 1'b0;
        kif.tx_full = 1'b0;
        lif.tx_full = 1'b0;
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        btn_tick    = 1'b0;
        kif.tx_full = 1'b0;
        lif.tx_full = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || kif.wr_uart !== 1'b0 || kif.w_data !== 8'h00 ||
            press_cnt !== 8'h00 || drop_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_state busy=%b wr=%b data=%h cnt=%h drop=%b required 0 0 00 00 0",
                     busy, kif.wr_uart, kif.w_data, press_cnt, drop_tick);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] exp_b [4];
        exp_b = '{8'h50, 8'h3D, 8'h30, 8'h31};
        cyc(1'b1, 1'b0);
        total++;
        if (s_busy !== 1'b0 || s_wr !== 1'b0 || s_drop !== 1'b0) begin
            bad++;
            $display("FAIL single_tick_cycle busy=%b wr=%b drop=%b required 0 0 0", s_busy, s_wr, s_drop);
        end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (s_wr !== 1'b1 || s_data !== exp_b[j] || s_busy !== 1'b1) begin
                bad++;
                $display("FAIL single_byte%0d wr=%b data=%h busy=%b required 1 %h 1",
                         j, s_wr, s_data, s_busy, exp_b[j]);
            end
        end
        cyc(1'b0, 1'b0);
        total++;
        if (s_busy !== 1'b0 || s_wr !== 1'b0 || s_cnt !== 8'h01) begin
            bad++;
            $display("FAIL single_end busy=%b wr=%b cnt=%h required 0 0 01", s_busy, s_wr, s_cnt);
        end
    endtask

    task automatic test_stall;
        logic [7:0] exp_b [4];
        int k;
        int writes;
        exp_b  = '{8'h50, 8'h3D, 8'h30, 8'h32};
        k      = 0;
        writes = 0;
        cyc(1'b1, 1'b0);
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c <= 4) begin
                cyc(1'b0, 1'b1);
                total++;
                if (s_wr !== 1'b0 || s_busy !== 1'b1 || s_data !== 8'h30) begin
                    bad++;
                    $display("FAIL stall_hold c=%0d wr=%b busy=%b data=%h required 0 1 30",
                             c, s_wr, s_busy, s_data);
                end
            end else begin
                cyc(1'b0, 1'b0);
                total++;
                if (s_wr !== 1'b1 || s_data !== exp_b[k]) begin
                    bad++;
                    $display("FAIL stall_byte%0d wr=%b data=%h required 1 %h", k, s_wr, s_data, exp_b[k]);
                end
                k++;
            end
            if (s_wr === 1'b1) writes++;
        end
        cyc(1'b0, 1'b0);
        if (s_wr === 1'b1) writes++;
        total++;
        if (writes !== 4 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_count writes=%0d busy=%b required 4 0", writes, s_busy);
        end
    endtask

    task automatic test_drop;
        logic [7:0] exp_b [4];
        int drops;
        exp_b = '{8'h50, 8'h3D, 8'h30, 8'h33};
        drops = 0;
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cyc((j == 1 || j == 3), 1'b0);
            if (s_drop === 1'b1) drops++;
            total++;
            if (s_data !== exp_b[j] || s_wr !== 1'b1) begin
                bad++;
                $display("FAIL drop_byte%0d wr=%b data=%h required 1 %h", j, s_wr, s_data, exp_b[j]);
            end
        end
        total++;
        if (drops !== 2 || s_cnt !== 8'h03) begin
            bad++;
            $display("FAIL drop_count drops=%0d cnt=%h required 2 03", drops, s_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4];
        exp_b = '{8'h50, 8'h3D, 8'h30, 8'h34};
        cyc(1'b1, 1'b0);
        total++;
        if (s_drop !== 1'b0 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept drop=%b busy=%b required 0 0", s_drop, s_busy);
        end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (s_wr !== 1'b1 || s_data !== exp_b[j]) begin
                bad++;
                $display("FAIL b2b_byte%0d wr=%b data=%h required 1 %h", j, s_wr, s_data, exp_b[j]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        logic [7:0] up [4];
        logic [7:0] lo [4];
        for (int n = 5; n <= 256; n++) begin
            e = 8'(n);
            cyc(1'b1, 1'b0);
            for (int j = 0; j < 4; j++) begin
                cyc(1'b0, 1'b0);
                up[j] = s_data;
                lo[j] = s_lc_data;
            end
            if (e == 8'h0A) begin
                total++;
                if (up[2] !== 8'h30 || up[3] !== 8'h41 || lo[2] !== 8'h30 || lo[3] !== 8'h61) begin
                    bad++;
                    $display("FAIL hex_0a up=%h%h lo=%h%h required 3041 3061", up[2], up[3], lo[2], lo[3]);
                end
            end
            if (e == 8'hFF) begin
                total++;
                if (up[2] !== 8'h46 || up[3] !== 8'h46 || lo[2] !== 8'h66 || lo[3] !== 8'h66) begin
                    bad++;
                    $display("FAIL hex_ff up=%h%h lo=%h%h required 4646 6666", up[2], up[3], lo[2], lo[3]);
                end
            end
            if (e == 8'h00) begin
                total++;
                if (up[0] !== 8'h50 || up[1] !== 8'h3D || up[2] !== 8'h30 || up[3] !== 8'h30 ||
                    press_cnt !== 8'h00) begin
                    bad++;
                    $display("FAIL wrap msg=%h%h%h%h cnt=%h required 503D3030 00",
                             up[0], up[1], up[2], up[3], press_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_b [4];
        exp_b = '{8'h50, 8'h3D, 8'h30, 8'h31};
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        total++;
        if (kif.wr_uart !== 1'b0 || busy !== 1'b0 || press_cnt !== 8'h00 || kif.w_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid wr=%b busy=%b cnt=%h data=%h required 0 0 00 00",
                     kif.wr_uart, busy, press_cnt, kif.w_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (s_wr !== 1'b1 || s_data !== exp_b[j]) begin
                bad++;
                $display("FAIL after_reset_byte%0d wr=%b data=%h required 1 %h", j, s_wr, s_data, exp_b[j]);
            end
        end
        total++;
        if (press_cnt !== 8'h01) begin
            bad++;
            $display("FAIL after_reset_cnt cnt=%h required 01", press_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_stall;
        test_drop;
        test_back_to_back;
        test_wrap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
